// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU opcodes and forwarding select encoding
package mips_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b0110,
        ALU_GT  = 4'b0111,
        ALU_LT  = 4'b1000,
        ALU_NOR = 4'b1001
    } alu_op_t;
    typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;
endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: per-operand bypass select between regfile, EX/MEM and MEM/WB
module fwd_unit import mips_pkg::*; #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] r,
    input  logic [DW-1:0] rf_data,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_dest,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_dest,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] data
);
    fwd_sel_t sel;
    always_comb begin
        sel  = r == '0 ? FWD_RF :
               exmem_reg_write && exmem_dest == r ? FWD_EXMEM :
               memwb_reg_write && memwb_dest == r ? FWD_MEMWB : FWD_RF;
        data = sel == FWD_EXMEM ? exmem_result : sel == FWD_MEMWB ? memwb_result : rf_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with operand bypass, load-use stall and stall-bubble counter
module id_ex_stage import mips_pkg::*; #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs,
    input  logic [RW-1:0]    id_rt,
    input  logic [RW-1:0]    id_dest,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic [DW-1:0]    id_imm,
    input  logic [4:0]       id_shamt,
    input  logic [3:0]       id_alu_ctrl,
    input  logic             id_alu_src,
    input  logic             id_shift,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             exmem_reg_write,
    input  logic [RW-1:0]    exmem_dest,
    input  logic [DW-1:0]    exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RW-1:0]    memwb_dest,
    input  logic [DW-1:0]    memwb_result,
    output logic             stall,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_data1,
    output logic [DW-1:0]    ex_data2,
    output logic [3:0]       ex_alu_ctrl,
    output logic [4:0]       ex_shamt,
    output logic [RW-1:0]    ex_dest,
    output logic [DW-1:0]    ex_store_data,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic [CNT_W-1:0] stall_count
);
    logic [RW-1:0] ex_rs, ex_rt;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm, fwd_rs, fwd_rt;
    logic          ex_alu_src, ex_shift;
    assign stall = ex_valid && ex_mem_read && ex_dest != '0 && id_valid &&
                   (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
    always_ff @(posedge Clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_dest       <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_shamt      <= '0;
            ex_alu_ctrl   <= '0;
            ex_alu_src    <= 1'b0;
            ex_shift      <= 1'b0;
        end else if (flush || stall) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_reg_write && id_valid;
            ex_mem_read   <= id_mem_read && id_valid;
            ex_mem_write  <= id_mem_write && id_valid;
            ex_mem_to_reg <= id_mem_to_reg && id_valid;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_dest       <= id_dest;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_shamt      <= id_shamt;
            ex_alu_ctrl   <= id_alu_ctrl;
            ex_alu_src    <= id_alu_src;
            ex_shift      <= id_shift;
        end
    end
    always_ff @(posedge Clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall && !flush && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
        .r(ex_rs), .rf_data(ex_rs_data),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .data(fwd_rs)
    );
    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
        .r(ex_rt), .rf_data(ex_rt_data),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
        .data(fwd_rt)
    );
    assign ex_data1      = ex_shift ? fwd_rt : fwd_rs;
    assign ex_data2      = ex_alu_src ? ex_imm : fwd_rt;
    assign ex_store_data = fwd_rt;
endmodule
